// File: rtl/timestamp_capture_pkg.sv
// rtl/timestamp_capture_pkg.sv - shared widths and constants for the timestamp capture block
package timestamp_capture_pkg;

  localparam int TS_WIDTH_DEFAULT = 32;
  localparam int DROP_CNT_W       = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Increment that sticks at DROP_CNT_MAX instead of wrapping to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/timestamp_capture_ts_fifo.sv
// rtl/timestamp_capture_ts_fifo.sv - power-of-two FIFO holding captured timestamps
module ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_en) begin
        level <= level + LW'(1);
      end else if (rd_en && !wr_en) begin
        level <= level - LW'(1);
      end
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/timestamp_capture.sv
// rtl/timestamp_capture.sv - captures count_i on events into a FIFO with drop counting
// Define TIMESTAMP_CAPTURE_DELTA_EN to store deltas from the previous accepted capture.
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TS_WIDTH_DEFAULT,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  event_i,
  output logic                  ts_valid_o,
  input  logic                  ts_ready_i,
  output logic [WIDTH-1:0]      ts_data_o,
  output logic [LW-1:0]         level_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                  clr_drop_i
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] capture_value;

  assign ts_valid_o = !fifo_empty;
  assign pop        = ts_valid_o && ts_ready_i;
  assign accept     = event_i && (!fifo_full || pop);
  assign drop       = event_i && fifo_full && !pop;

`ifdef TIMESTAMP_CAPTURE_DELTA_EN
  logic [WIDTH-1:0] ref_q;

  // Only accepted captures move the reference, so the stored deltas sum to the absolute count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (accept) begin
      ref_q <= count_i;
    end
  end

  assign capture_value = count_i - ref_q;
`else
  assign capture_value = count_i;
`endif

  // Clear has priority over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
    end else if (clr_drop_i) begin
      drop_cnt_o <= '0;
    end else if (drop) begin
      drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

  ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (capture_value),
    .pop       (pop),
    .pop_data  (ts_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

endmodule

// File: tb/tb_timestamp_capture.sv
// tb/tb_timestamp_capture.sv - directed self-checking bench for timestamp_capture
module tb_timestamp_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] count_i;
  logic        event_i;
  logic        ts_valid_o;
  logic        ts_ready_i;
  logic [31:0] ts_data_o;
  logic [2:0]  level_o;
  logic [7:0]  drop_cnt_o;
  logic        clr_drop_i;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] model_ref = '0;
  logic [31:0] expq [$];
  logic [31:0] e;

  timestamp_capture #(.DEPTH(4), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_i    (count_i),
    .event_i    (event_i),
    .ts_valid_o (ts_valid_o),
    .ts_ready_i (ts_ready_i),
    .ts_data_o  (ts_data_o),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o),
    .clr_drop_i (clr_drop_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stored value for an accepted capture of c.
  function automatic logic [31:0] stored(input logic [31:0] c);
    logic [31:0] v;
`ifdef TIMESTAMP_CAPTURE_DELTA_EN
    v = c - model_ref;
`else
    v = c;
`endif
    model_ref = c;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_ref = '0;
    expq.delete();
  endtask

  initial begin
    rst_n = 1'b0; count_i = '0; event_i = 1'b0; ts_ready_i = 1'b0; clr_drop_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_valid", 32'(ts_valid_o), 32'd0);
    check("reset_level", 32'(level_o), 32'd0);
    check("reset_drop", 32'(drop_cnt_o), 32'd0);
    check("reset_data", ts_data_o, 32'd0);

    // single capture with consumer ready
    count_i = 32'h10; event_i = 1'b1; ts_ready_i = 1'b1;
    tick();
    event_i = 1'b0;
    e = stored(32'h10);
    check("single_valid", 32'(ts_valid_o), 32'd1);
    check("single_data", ts_data_o, e);
    tick();
    check("single_level_after_pop", 32'(level_o), 32'd0);
    check("single_valid_after_pop", 32'(ts_valid_o), 32'd0);

    // fill to full, fifth event dropped
    do_reset();
    ts_ready_i = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      count_i = 32'(c); event_i = 1'b1;
      tick();
      if (c <= 8) expq.push_back(stored(32'(c)));
    end
    event_i = 1'b0;
    check("fill_level", 32'(level_o), 32'd4);
    check("fill_drop", 32'(drop_cnt_o), 32'd1);
    check("hold_data_a", ts_data_o, expq[0]);
    tick();
    check("hold_data_b", ts_data_o, expq[0]);
    ts_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(ts_valid_o), 32'd1);
      check("drain_data", ts_data_o, expq.pop_front());
      tick();
    end
    check("drain_empty", 32'(level_o), 32'd0);
    tick();
    check("empty_pop_ignored", 32'(level_o), 32'd0);

    // push and pop together while full
    ts_ready_i = 1'b0;
    for (int c = 32'h20; c <= 32'h23; c++) begin
      count_i = 32'(c); event_i = 1'b1;
      tick();
      expq.push_back(stored(32'(c)));
    end
    count_i = 32'h24; event_i = 1'b1; ts_ready_i = 1'b1;
    tick();
    event_i = 1'b0; ts_ready_i = 1'b0;
    void'(expq.pop_front());
    expq.push_back(stored(32'h24));
    check("full_pushpop_level", 32'(level_o), 32'd4);
    check("full_pushpop_drop", 32'(drop_cnt_o), 32'd1);
    ts_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pushpop_data", ts_data_o, expq.pop_front());
      tick();
    end
    ts_ready_i = 1'b0;

    // counter wrap
    do_reset();
    count_i = 32'hFFFF_FFFE; event_i = 1'b1;
    tick();
    count_i = 32'h0000_0003;
    tick();
    event_i = 1'b0;
    check("wrap_first", ts_data_o, 32'hFFFF_FFFE);
    ts_ready_i = 1'b1;
    tick();
    ts_ready_i = 1'b0;
`ifdef TIMESTAMP_CAPTURE_DELTA_EN
    check("wrap_second", ts_data_o, 32'h0000_0005);
`else
    check("wrap_second", ts_data_o, 32'h0000_0003);
`endif

    // saturation, clear, reset mid-stream
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      count_i = 32'(c); event_i = 1'b1;
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      count_i = 32'(100 + i);
      tick();
    end
    check("sat_drop", 32'(drop_cnt_o), 32'd255);
    check("sat_level", 32'(level_o), 32'd4);
    check("sat_head", ts_data_o, 32'd1);
    clr_drop_i = 1'b1;
    tick();
    clr_drop_i = 1'b0;
    check("clear_wins", 32'(drop_cnt_o), 32'd0);
    tick();
    event_i = 1'b0;
    check("drop_after_clear", 32'(drop_cnt_o), 32'd1);
    rst_n = 1'b0; event_i = 1'b1; ts_ready_i = 1'b1;
    tick();
    check("midrst_valid", 32'(ts_valid_o), 32'd0);
    check("midrst_level", 32'(level_o), 32'd0);
    check("midrst_drop", 32'(drop_cnt_o), 32'd0);
    check("midrst_data", ts_data_o, 32'd0);
    rst_n = 1'b1; event_i = 1'b0; ts_ready_i = 1'b0;
    tick();
    check("post_rst_level", 32'(level_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timestamp_capture.md
TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 32, meaning timestamp width (matches upstream counter result).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port count_i  input  WIDTH  running count from the upstream counter.
REQ-006 SHALL have port event_i  input  1  capture request, sampled each posedge.
REQ-007 SHALL have port ts_valid_o  output  1  head entry available.
REQ-008 SHALL have port ts_ready_i  input  1  consumer accepts head entry.
REQ-009 SHALL have port ts_data_o  output  WIDTH  head entry value.
REQ-010 SHALL have port level_o  output  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port drop_cnt_o  output  8  dropped-event count, saturating.
REQ-012 SHALL have port clr_drop_i  input  1  clears drop_cnt_o.

Function
REQ-013 SHALL capture count_i on each posedge where event_i=1 and push it into the FIFO.
REQ-014 SHALL assert ts_valid_o the cycle after a push into an empty FIFO (1-cycle latency); ts_valid_o = (level_o != 0), registered.
REQ-015 SHALL pop the head on posedge when ts_valid_o=1 and ts_ready_i=1; ts_data_o holds stable while ts_valid_o=1 and ts_ready_i=0.
REQ-016 SHALL deliver entries in capture order (FIFO); pointers wrap modulo DEPTH.
REQ-017 Push and pop in the same cycle SHALL both take effect, level unchanged, including when full (freed slot reused).
REQ-018 Event when full and no pop SHALL be dropped, FIFO contents unchanged, drop_cnt_o incremented, saturating at 255.
REQ-019 clr_drop_i=1 SHALL zero drop_cnt_o next cycle; a same-cycle drop SHALL be lost (clear wins).
REQ-020 Pop when empty SHALL be impossible (ts_valid_o=0); ts_ready_i ignored.
REQ-021 count_i wrap 0xFFFFFFFF->0 SHALL require no special handling; values stored verbatim.

Reset
REQ-022 rst_n=0 at posedge SHALL flush FIFO: ts_valid_o=0, level_o=0, drop_cnt_o=0, ts_data_o=0, pointers=0, delta reference=0.
REQ-023 Events and handshakes in a reset cycle SHALL be ignored; reset mid-stream discards all pending entries.

Configuration
REQ-024 With macro TIMESTAMP_CAPTURE_DELTA_EN defined, stored value SHALL be count_i minus the last accepted capture, modulo 2^WIDTH; first capture after reset relative to 0.
REQ-025 In delta mode only accepted (not dropped) captures SHALL update the reference, so delta sum equals absolute count.
REQ-026 Without the macro, stored value SHALL be count_i absolute; no reference register present.

Structure
REQ-027 Package timestamp_capture_pkg SHALL hold TS_WIDTH_DEFAULT=32, DROP_CNT_W=8 and the saturating-max constant.
REQ-028 Storage and pointers SHALL be in sub-module ts_fifo (push/pop/full/empty/level); top holds capture, delta, drop logic.

Verification
REQ-029 Reset, count_i=0x10, event pulse, ts_ready_i=1 -> ts_valid_o one cycle later, ts_data_o=0x10, then level_o=0.
REQ-030 DEPTH=4, ts_ready_i=0, events at counts 5,6,7,8,9 -> level_o=4, drop_cnt_o=1, drained 5,6,7,8.
REQ-031 Full FIFO, event and ts_ready_i=1 same cycle -> no drop, level_o stays 4, new value at tail.
REQ-032 Delta build, events at 0xFFFFFFFE then 0x00000003 -> entries 0xFFFFFFFE, 0x00000005.
REQ-033 300 drops while full -> drop_cnt_o=255; clr_drop_i -> 0; rst_n low mid-stream -> ts_valid_o=0 next cycle.
